// File: rtl/d2g_buffer_if.sv
// rtl/d2g_buffer_if.sv - write/read handshake bundle for the decoder-to-general repacking buffer
interface d2g_buffer_if #(
    parameter int WR_DATA_WIDTH = 11,
    parameter int RD_DATA_WIDTH = 8
);
    logic [WR_DATA_WIDTH-1:0] wr_data;
    logic                     wr_valid;
    logic                     wr_ready;
    logic [RD_DATA_WIDTH-1:0] rd_data;
    logic                     rd_valid;
    logic                     rd_ready;

    modport master (
        output wr_data, wr_valid, rd_ready,
        input  wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  wr_data, wr_valid, rd_ready,
        output wr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/d2g_buffer.sv
// rtl/d2g_buffer.sv - repacks an LSB-first bit stream from WR_DATA_WIDTH words into RD_DATA_WIDTH words
module d2g_buffer #(
    parameter int WR_DATA_WIDTH   = 11,
    parameter int RD_DATA_WIDTH   = 8,
    parameter int BUF_BUFFER_SIZE = 18
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    d2g_buffer_if.slave                            bus,
    output logic [$clog2(BUF_BUFFER_SIZE+1)-1:0]   count
);
    localparam int CW = $clog2(BUF_BUFFER_SIZE + 1);
    // One extra bit so count + WR_DATA_WIDTH cannot wrap in the space check.
    localparam logic [CW:0]   WR_EXT  = (CW+1)'(WR_DATA_WIDTH);
    localparam logic [CW:0]   BUF_EXT = (CW+1)'(BUF_BUFFER_SIZE);
    localparam logic [CW-1:0] WR_CNT  = CW'(WR_DATA_WIDTH);
    localparam logic [CW-1:0] RD_CNT  = CW'(RD_DATA_WIDTH);

    // A buffer smaller than this could deadlock: not enough room for a word, not enough bits for a byte.
    if (BUF_BUFFER_SIZE < WR_DATA_WIDTH + RD_DATA_WIDTH - 1) begin : g_size_check
        $error("d2g_buffer: BUF_BUFFER_SIZE too small for WR/RD widths");
    end

    logic [BUF_BUFFER_SIZE-1:0] buffer;
    logic [BUF_BUFFER_SIZE-1:0] buffer_next;
    logic [BUF_BUFFER_SIZE-1:0] shifted;
    logic [BUF_BUFFER_SIZE-1:0] wr_word;
    logic [CW-1:0]              count_next;
    logic [CW-1:0]              base;
    logic                       wr_fire;
    logic                       rd_fire;

    // Space is judged on the registered count only; a read in the same cycle grants no extra credit.
    assign bus.wr_ready = ({1'b0, count} + WR_EXT) <= BUF_EXT;
    assign bus.rd_valid = count >= RD_CNT;
    assign bus.rd_data  = buffer[RD_DATA_WIDTH-1:0];

    // Next buffer/count: retire the oldest output word first, then append the new word behind the survivors.
    always_comb begin
        wr_fire     = bus.wr_valid && bus.wr_ready;
        rd_fire     = bus.rd_valid && bus.rd_ready;
        shifted     = rd_fire ? (buffer >> RD_DATA_WIDTH) : buffer;
        base        = rd_fire ? (count - RD_CNT) : count;
        wr_word     = BUF_BUFFER_SIZE'(bus.wr_data);
        buffer_next = shifted;
        count_next  = base;
        if (wr_fire) begin
            buffer_next = shifted | (wr_word << base);
            count_next  = base + WR_CNT;
        end
    end

    // State register; unused positions stay zero because shifts fill with zeros and writes land above count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buffer <= '0;
            count  <= '0;
        end else begin
            buffer <= buffer_next;
            count  <= count_next;
        end
    end
endmodule
